// File: rtl/clk_time_setter.sv
// Button-driven time entry for the 24-hour clock counter: it captures the live time,
// lets the user edit hour/min/sec with inc/dec and auto-repeat, then sends a one-cycle load strobe.
//
// state       | meaning
// S_IDLE      | not editing, waiting for a mode press
// S_EDIT_HOUR | inc/dec adjust the hour field
// S_EDIT_MIN  | inc/dec adjust the minute field
// S_EDIT_SEC  | inc/dec adjust the second field
// S_COMMIT    | timeset_o high for one cycle
module clk_time_setter #(
  parameter int HOUR_MAX       = 23,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic [4:0] hour_set_o,
  output logic [5:0] min_set_o,
  output logic [5:0] sec_set_o,
  output logic       timeset_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_DLY_LD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LD = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    HMAX       = 5'(HOUR_MAX);
  localparam logic [5:0]    MSMAX      = 6'd59;

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC, S_COMMIT
  } state_e;

  function automatic logic [4:0] wrap5(input logic [4:0] v, input logic [4:0] vmax,
                                       input logic up);
    if (up) return (v == vmax) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? vmax : v - 5'd1;
  endfunction

  function automatic logic [5:0] wrap6(input logic [5:0] v, input logic [5:0] vmax,
                                       input logic up);
    if (up) return (v == vmax) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

  state_e          state_q, state_d;
  logic            mode_prev_q, mode_prev_d;
  logic            inc_prev_q, inc_prev_d;
  logic            dec_prev_q, dec_prev_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            rpt_act_q, rpt_act_d;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            timeset_q, timeset_d;
  logic            editing_q, editing_d;
  logic [1:0]      field_q, field_d;

  logic mode_ev, inc_ev, dec_ev, step;

  always_comb begin
    state_d     = state_q;
    mode_prev_d = mode_i;
    inc_prev_d  = inc_i;
    dec_prev_d  = dec_i;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    rpt_act_d   = rpt_act_q;
    rpt_cnt_d   = rpt_cnt_q;
    tmo_d       = tmo_q;
    step        = 1'b0;

    mode_ev = mode_i & ~mode_prev_q;
    inc_ev  = inc_i & ~inc_prev_q;
    dec_ev  = dec_i & ~dec_prev_q;

    case (state_q)
      S_IDLE: begin
        if (mode_ev) begin
          hour_d    = (hour_i > HMAX)  ? 5'd0 : hour_i;
          min_d     = (min_i  > MSMAX) ? 6'd0 : min_i;
          sec_d     = (sec_i  > MSMAX) ? 6'd0 : sec_i;
          tmo_d     = '0;
          rpt_act_d = 1'b0;
          rpt_cnt_d = '0;
          state_d   = S_EDIT_HOUR;
        end
      end
      S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC: begin
        if (mode_ev) begin
          rpt_act_d = 1'b0;
          rpt_cnt_d = '0;
          state_d   = (state_q == S_EDIT_HOUR) ? S_EDIT_MIN :
                      (state_q == S_EDIT_MIN)  ? S_EDIT_SEC : S_COMMIT;
        end else if (inc_i && dec_i) begin
          rpt_act_d = 1'b0;
          rpt_cnt_d = '0;
        end else if (inc_ev || dec_ev) begin
          step      = 1'b1;
          rpt_act_d = 1'b1;
          rpt_cnt_d = RPT_DLY_LD;
        end else if ((inc_i || dec_i) && rpt_act_q) begin
          // Hold counter runs down to zero, fires a step, then reloads with the period.
          if (rpt_cnt_q == '0) begin
            step      = 1'b1;
            rpt_cnt_d = RPT_PER_LD;
          end else begin
            rpt_cnt_d = rpt_cnt_q - RW'(1);
          end
        end else begin
          rpt_act_d = 1'b0;
          rpt_cnt_d = '0;
        end

        // A step implies exactly one of inc/dec is high, so inc_i gives the direction.
        if (step) begin
          case (state_q)
            S_EDIT_HOUR: hour_d = wrap5(hour_q, HMAX, inc_i);
            S_EDIT_MIN:  min_d  = wrap6(min_q, MSMAX, inc_i);
            default:     sec_d  = wrap6(sec_q, MSMAX, inc_i);
          endcase
        end

        if (mode_ev || inc_ev || dec_ev || step) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d     = '0;
          rpt_act_d = 1'b0;
          rpt_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    timeset_d = (state_d == S_COMMIT);
    editing_d = (state_d == S_EDIT_HOUR) || (state_d == S_EDIT_MIN) ||
                (state_d == S_EDIT_SEC);
    case (state_d)
      S_EDIT_HOUR: field_d = 2'd1;
      S_EDIT_MIN:  field_d = 2'd2;
      S_EDIT_SEC:  field_d = 2'd3;
      default:     field_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      dec_prev_q  <= 1'b1;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      rpt_act_q   <= 1'b0;
      rpt_cnt_q   <= '0;
      tmo_q       <= '0;
      timeset_q   <= 1'b0;
      editing_q   <= 1'b0;
      field_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      dec_prev_q  <= dec_prev_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      rpt_act_q   <= rpt_act_d;
      rpt_cnt_q   <= rpt_cnt_d;
      tmo_q       <= tmo_d;
      timeset_q   <= timeset_d;
      editing_q   <= editing_d;
      field_q     <= field_d;
    end
  end

  assign hour_set_o = hour_q;
  assign min_set_o  = min_q;
  assign sec_set_o  = sec_q;
  assign timeset_o  = timeset_q;
  assign editing_o  = editing_q;
  assign field_o    = field_q;

endmodule

// File: tb/tb_clk_time_setter.sv
// Directed bench for clk_time_setter: linear button sequences with hand-computed results.
module tb_clk_time_setter;

  logic       clk_i, reset_i, mode_i, inc_i, dec_i;
  logic [4:0] hour_i;
  logic [5:0] min_i, sec_i;
  logic [4:0] hour_set_o;
  logic [5:0] min_set_o, sec_set_o;
  logic       timeset_o, editing_o;
  logic [1:0] field_o;

  int n_assert = 0;
  int n_fail   = 0;
  int ts_cnt   = 0;

  clk_time_setter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mode_i(mode_i), .inc_i(inc_i), .dec_i(dec_i),
    .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
    .hour_set_o(hour_set_o), .min_set_o(min_set_o), .sec_set_o(sec_set_o),
    .timeset_o(timeset_o), .editing_o(editing_o), .field_o(field_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (timeset_o === 1'b1) ts_cnt++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic m, input logic i, input logic d);
    mode_i = m; inc_i = i; dec_i = d;
    tick();
    mode_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; mode_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
    hour_i = 5'd0; min_i = 6'd0; sec_i = 6'd0;
    repeat (3) tick();
    chk("rst_editing", editing_o, 0);
    chk("rst_field", field_o, 0);
    chk("rst_timeset", timeset_o, 0);
    chk("rst_hour", hour_set_o, 0);
    chk("rst_min", min_set_o, 0);
    chk("rst_sec", sec_set_o, 0);
    reset_i = 1'b0;
    tick();

    // Basic commit: 10/20/30 -> inc x2 hour, dec x1 min -> 12/19/30
    hour_i = 5'd10; min_i = 6'd20; sec_i = 6'd30;
    mode_i = 1'b1;
    tick();
    chk("cap_field", field_o, 1);
    chk("cap_editing", editing_o, 1);
    chk("cap_hour", hour_set_o, 10);
    chk("cap_min", min_set_o, 20);
    chk("cap_sec", sec_set_o, 30);
    mode_i = 1'b0;
    hour_i = 5'd5; min_i = 6'd1; sec_i = 6'd2;
    tick();
    inc_i = 1'b1;
    tick();
    chk("inc1_hour", hour_set_o, 11);
    inc_i = 1'b0;
    tick();
    pulse(1'b0, 1'b1, 1'b0);
    chk("inc2_hour", hour_set_o, 12);
    pulse(1'b1, 1'b0, 1'b0);
    chk("adv_min_field", field_o, 2);
    pulse(1'b0, 1'b0, 1'b1);
    chk("dec_min", min_set_o, 19);
    pulse(1'b1, 1'b0, 1'b0);
    chk("adv_sec_field", field_o, 3);
    mode_i = 1'b1;
    tick();
    chk("commit_ts", timeset_o, 1);
    chk("commit_editing", editing_o, 0);
    chk("commit_field", field_o, 0);
    chk("commit_hour", hour_set_o, 12);
    chk("commit_min", min_set_o, 19);
    chk("commit_sec", sec_set_o, 30);
    mode_i = 1'b0;
    tick();
    chk("post_commit_ts", timeset_o, 0);
    chk("post_commit_editing", editing_o, 0);
    chk("ts_count_1", ts_cnt, 1);

    // Wraparound: 23/59/0 -> 0/0/59
    hour_i = 5'd23; min_i = 6'd59; sec_i = 6'd0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("wrap_cap_hour", hour_set_o, 23);
    pulse(1'b0, 1'b1, 1'b0);
    chk("wrap_hour", hour_set_o, 0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("wrap_min", min_set_o, 0);
    chk("wrap_hour_kept", hour_set_o, 0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("wrap_sec", sec_set_o, 59);
    mode_i = 1'b1;
    tick();
    chk("wrap_commit_ts", timeset_o, 1);
    chk("wrap_commit_hour", hour_set_o, 0);
    chk("wrap_commit_min", min_set_o, 0);
    chk("wrap_commit_sec", sec_set_o, 59);
    mode_i = 1'b0;
    tick();

    // Clamp on capture
    hour_i = 5'd24; min_i = 6'd60; sec_i = 6'd63;
    pulse(1'b1, 1'b0, 1'b0);
    chk("clamp_hour", hour_set_o, 0);
    chk("clamp_min", min_set_o, 0);
    chk("clamp_sec", sec_set_o, 0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("clamp_inc_hour", hour_set_o, 1);

    // Auto-repeat on minutes from 0: steps at event, +16, +20, +24, +28
    pulse(1'b1, 1'b0, 1'b0);
    chk("rpt_field", field_o, 2);
    inc_i = 1'b1;
    repeat (16) tick();
    chk("rpt_before_first", min_set_o, 1);
    tick();
    chk("rpt_first", min_set_o, 2);
    repeat (12) tick();
    chk("rpt_total", min_set_o, 5);
    inc_i = 1'b0;
    tick();
    chk("rpt_release", min_set_o, 5);
    pulse(1'b1, 1'b0, 1'b0);
    mode_i = 1'b1;
    tick();
    chk("rpt_commit_ts", timeset_o, 1);
    chk("rpt_commit_hour", hour_set_o, 1);
    chk("rpt_commit_min", min_set_o, 5);
    chk("rpt_commit_sec", sec_set_o, 0);
    mode_i = 1'b0;
    tick();
    chk("ts_count_3", ts_cnt, 3);

    // Conflicts
    hour_i = 5'd7; min_i = 6'd8; sec_i = 6'd9;
    pulse(1'b1, 1'b0, 1'b0);
    mode_i = 1'b1; inc_i = 1'b1;
    tick();
    chk("conf_mode_field", field_o, 2);
    chk("conf_mode_hour", hour_set_o, 7);
    mode_i = 1'b0; inc_i = 1'b0;
    tick();
    chk("conf_mode_min", min_set_o, 8);
    inc_i = 1'b1; dec_i = 1'b1;
    repeat (20) tick();
    chk("conf_both_min", min_set_o, 8);
    chk("conf_both_hour", hour_set_o, 7);
    inc_i = 1'b0; dec_i = 1'b0;
    tick();

    // Timeout in EDIT_SEC
    mode_i = 1'b1;
    tick();
    chk("tmo_field", field_o, 3);
    mode_i = 1'b0;
    repeat (1023) tick();
    chk("tmo_still_editing", editing_o, 1);
    chk("tmo_still_field", field_o, 3);
    tick();
    chk("tmo_editing", editing_o, 0);
    chk("tmo_field_idle", field_o, 0);
    chk("tmo_no_strobe", ts_cnt, 3);
    chk("tmo_hour", hour_set_o, 7);
    chk("tmo_min", min_set_o, 8);
    chk("tmo_sec", sec_set_o, 9);

    // Reset mid-edit with inc held through release
    hour_i = 5'd3; min_i = 6'd4; sec_i = 6'd5;
    pulse(1'b1, 1'b0, 1'b0);
    inc_i = 1'b1;
    tick();
    chk("rst_edit_hour", hour_set_o, 4);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_async_editing", editing_o, 0);
    chk("rst_async_hour", hour_set_o, 0);
    chk("rst_async_field", field_o, 0);
    repeat (2) tick();
    reset_i = 1'b0;
    repeat (3) tick();
    chk("rst_rel_hour", hour_set_o, 0);
    chk("rst_rel_min", min_set_o, 0);
    chk("rst_rel_sec", sec_set_o, 0);
    chk("rst_rel_editing", editing_o, 0);
    chk("rst_rel_field", field_o, 0);
    chk("rst_rel_timeset", timeset_o, 0);
    chk("rst_no_strobe", ts_cnt, 3);
    mode_i = 1'b1;
    tick();
    chk("held_inc_cap_hour", hour_set_o, 3);
    chk("held_inc_field", field_o, 1);
    mode_i = 1'b0;
    repeat (20) tick();
    chk("held_inc_no_step", hour_set_o, 3);
    inc_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
